m72_video_timing: RTL and testbench
===================================

# m72_video_timing

Raster timing generator for the M72 video path. Derives the 8 MHz pixel enable from `CLK_32M` and runs the horizontal and vertical counters. Produces the `HE`/`VE` beam position, `CE_PIX`, blanking and sync consumed by the B-D tilemap/palette board and the video output. Also hosts the CPU-programmable raster-compare interrupt and the vblank interrupt, with request/acknowledge latches.

## Interface
Parameters:
- `H_TOTAL`, 512: pixels per line; `HE` counts 0..H_TOTAL-1.
- `H_START`, 64: first visible `HE`.
- `H_VIS`, 384: visible pixels per line.
- `HS_START`, 472; `HS_LEN`, 32: HSYNC position and width, in pixels.
- `V_TOTAL`, 284: lines per frame; `VE` counts 0..V_TOTAL-1.
- `V_START`, 16: first visible `VE`.
- `V_VIS`, 256: visible lines.
- `VS_START`, 276; `VS_LEN`, 4: VSYNC position and height, in lines.

Ports:
- `CLK_32M` in 1: sole clock.
- `RESET` in 1: reset, synchronous, active-high.
- `IOWR` in 1: CPU I/O write strobe, one cycle.
- `A` in 20: CPU address.
- `DIN` in 16: CPU write data.
- `BYTE_SEL` in 2: byte lanes; bit 0 is low byte, bit 1 is high byte.
- `INT_ACK` in 2: bit 0 clears the vblank request, bit 1 clears the raster request. Pulses.
- `CE_PIX` out 1: pixel enable, one cycle in four.
- `HE` out 9: horizontal position.
- `VE` out 9: vertical position.
- `HBLANK`, `VBLANK`, `HSYNC`, `VSYNC` out 1 each: active-high.
- `VBL_IRQ`, `RAST_IRQ` out 1 each: level interrupt requests.

## Operation
- **Divider.** A 2-bit counter `div` increments every clock. `CE_PIX` is registered high for exactly the clock in which `div==3`.
- **Horizontal counter.** On a clock with `CE_PIX==1`, `HE` increments. It wraps from `H_TOTAL-1` to 0.
- **Vertical counter.** `VE` increments when `HE` wraps. It wraps from `V_TOTAL-1` to 0.
- **Blanking and sync.** All four signals are registered and computed from the next-state `HE`/`VE`, so they align with the position they describe.
  - `HBLANK` = !(`H_START` <= HE < `H_START+H_VIS`).
  - `VBLANK` = !(`V_START` <= VE < `V_START+V_VIS`).
  - `HSYNC` = `HS_START` <= HE < `HS_START+HS_LEN`.
  - `VSYNC` = `VS_START` <= VE < `VS_START+VS_LEN`.
- **Raster compare register `RCMP[8:0]`.**
  - Written when `IOWR & A[7:1]==7'h20`.
  - `BYTE_SEL[0]` loads `RCMP[7:0]` from `DIN[7:0]`.
  - `BYTE_SEL[1]` loads `RCMP[8]` from `DIN[8]`.
  - Any other address is ignored.
- **Vblank request.** `VBL_IRQ` sets on the `CE_PIX` tick where the counters become `HE==0`, `VE==V_START+V_VIS`.
- **Raster request.** `RAST_IRQ` sets on the `CE_PIX` tick where the counters become `HE==H_START+H_VIS` and `VE==RCMP`. `RCMP>=V_TOTAL` never matches.
- **Request clearing.** Each request clears only on its `INT_ACK` bit. If set and clear occur in the same clock, set wins.
- **Reset.** Applies to every register. In-progress lines are abandoned; there is no partial-frame completion.

## Timing
- **Reset values.** `div=0`, `CE_PIX=0`, `HE=0`, `VE=0`, `HBLANK=1`, `VBLANK=1`, `HSYNC=0`, `VSYNC=0`, `RCMP=9'h1FF`, `VBL_IRQ=0`, `RAST_IRQ=0`.
- **First pixel enable.** The first `CE_PIX` is high on the 4th clock after `RESET` falls.
- **Counter updates.** `HE`/`VE` change on the clock edge that ends a `CE_PIX`-high cycle, and are stable for 4 clocks.
- **Frame period.** 4·512·284 = 581632 clocks, about 55.0 Hz at 32 MHz.
- **Register write latency.** An `RCMP` write is visible to the compare on the next clock. A write that lands on the matching tick uses the old value.
- **Interrupt request latency.** 0 cycles relative to the triggering `HE`/`VE` update: both change on the same edge.
- **Acknowledge latency.** The request is low 1 clock after an `INT_ACK` pulse.

## Configuration
- **`M72_SYNC_ADJUST_EN` defined:**
  - Adds ports `H_ADJ` in 4 and `V_ADJ` in 4, both signed two's complement.
  - Effective sync windows become `HS_START+H_ADJ` and `VS_START+V_ADJ`, evaluated modulo `H_TOTAL`/`V_TOTAL`.
  - Adjust inputs are sampled only when `HE==0` and `VE==0`, so a change never splits a frame.
  - Blanking and interrupts are unaffected.
- **Undefined:** no adjust ports; sync windows are fixed at their parameters.

## Test plan
- Reset, then run 600000 clocks.
  - Expect `CE_PIX` period 4 and 512 `CE_PIX` per line.
  - Expect `VE` wrap from 283 to 0, and 145408 `CE_PIX` per frame.
- Blanking and sync edges:
  - `HBLANK` falls at HE=64 and rises at HE=448.
  - `VBLANK` falls at VE=16 and rises at VE=272.
  - `HSYNC` is high for HE 472..503.
  - `VSYNC` is high for VE 276..279.
- Write `RCMP=100`:
  - IOWR at A=0x40 with BYTE_SEL=2'b11 and DIN=16'h0064.
  - Expect `RAST_IRQ` to rise as HE becomes 448 on VE=100, and no other rise in the frame.
  - Pulse `INT_ACK[1]`; expect the request low next clock.
- Simultaneous events:
  - Hold `INT_ACK[0]` high across the VE=272, HE=0 tick; expect `VBL_IRQ` to be 1 afterward.
  - Assert `RESET` mid-line at HE=200; expect all outputs at their reset values next clock.
- Write `RCMP=300` (beyond `V_TOTAL`) with a high-byte-only write followed by a low-byte write; expect no `RAST_IRQ` over 2 frames.
- With `M72_SYNC_ADJUST_EN` defined:
  - Set `H_ADJ=-2`; expect `HSYNC` at HE 470..501 from the next frame.
  - Change it mid-frame; expect no effect until HE=0, VE=0.

Source files
------------

// File: rtl/m72_video_timing.sv
// M72 raster timing: 8 MHz pixel enable from CLK_32M, beam counters, blanking/sync, vblank and raster IRQs.
// Optional M72_SYNC_ADJUST_EN adds frame-latched signed H_ADJ/V_ADJ sync window offsets.
module m72_video_timing #(
   parameter int unsigned H_TOTAL  = 512,
   parameter int unsigned H_START  = 64,
   parameter int unsigned H_VIS    = 384,
   parameter int unsigned HS_START = 472,
   parameter int unsigned HS_LEN   = 32,
   parameter int unsigned V_TOTAL  = 284,
   parameter int unsigned V_START  = 16,
   parameter int unsigned V_VIS    = 256,
   parameter int unsigned VS_START = 276,
   parameter int unsigned VS_LEN   = 4
) (
   input  logic        CLK_32M,
   input  logic        RESET,
   input  logic        IOWR,
   input  logic [19:0] A,
   input  logic [15:0] DIN,
   input  logic [1:0]  BYTE_SEL,
   input  logic [1:0]  INT_ACK,
`ifdef M72_SYNC_ADJUST_EN
   input  logic [3:0]  H_ADJ,
   input  logic [3:0]  V_ADJ,
`endif
   output logic        CE_PIX,
   output logic [8:0]  HE,
   output logic [8:0]  VE,
   output logic        HBLANK,
   output logic        VBLANK,
   output logic        HSYNC,
   output logic        VSYNC,
   output logic        VBL_IRQ,
   output logic        RAST_IRQ
);

   localparam int unsigned DIV_W = 2;
   localparam int unsigned POS_W = 9;
   localparam int unsigned ADJ_W = 4;

   logic [DIV_W-1:0] div_q, div_d;
   logic             ce_q, ce_d;
   logic [POS_W-1:0] he_q, he_d;
   logic [POS_W-1:0] ve_q, ve_d;
   logic             hblank_q, hblank_d;
   logic             vblank_q, vblank_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic [POS_W-1:0] rcmp_q, rcmp_d;
   logic             vbl_q, vbl_d;
   logic             rast_q, rast_d;
   logic             vbl_set_c;
   logic             rast_set_c;
   logic             unused_c;

`ifdef M72_SYNC_ADJUST_EN
   logic [ADJ_W-1:0] hadj_q, hadj_d;
   logic [ADJ_W-1:0] vadj_q, vadj_d;

   // Circular window test: start may fall outside 0..total-1 by less than one total.
   function automatic logic in_window(input logic [POS_W-1:0] pos, input int start,
                                      input int len, input int total);
      int s;
      int off;
      s = start;
      if (s < 0) s = s + total;
      else if (s >= total) s = s - total;
      off = int'(32'(pos)) + total - s;
      if (off >= total) off = off - total;
      return off < len;
   endfunction
`endif

   assign unused_c = ^{A[19:8], A[0], DIN[15:9]};

   always_comb begin
      div_d    = div_q + 2'd1;
      ce_d     = (div_d == 2'd3);
      he_d     = he_q;
      ve_d     = ve_q;
      rcmp_d   = rcmp_q;

      if (ce_q) begin
         if (32'(he_q) == H_TOTAL - 1) begin
            he_d = '0;
            if (32'(ve_q) == V_TOTAL - 1) ve_d = '0;
            else                          ve_d = ve_q + 9'd1;
         end else begin
            he_d = he_q + 9'd1;
         end
      end

      // Blanking and sync describe the position being entered on this edge.
      hblank_d = !((32'(he_d) >= H_START) && (32'(he_d) < H_START + H_VIS));
      vblank_d = !((32'(ve_d) >= V_START) && (32'(ve_d) < V_START + V_VIS));
`ifdef M72_SYNC_ADJUST_EN
      hadj_d   = hadj_q;
      vadj_d   = vadj_q;
      if (he_q == '0 && ve_q == '0) begin
         hadj_d = H_ADJ;
         vadj_d = V_ADJ;
      end
      hsync_d  = in_window(he_d, int'(HS_START) + int'($signed(hadj_q)), int'(HS_LEN), int'(H_TOTAL));
      vsync_d  = in_window(ve_d, int'(VS_START) + int'($signed(vadj_q)), int'(VS_LEN), int'(V_TOTAL));
`else
      hsync_d  = (32'(he_d) >= HS_START) && (32'(he_d) < HS_START + HS_LEN);
      vsync_d  = (32'(ve_d) >= VS_START) && (32'(ve_d) < VS_START + VS_LEN);
`endif

      if (IOWR && A[7:1] == 7'h20) begin
         if (BYTE_SEL[0]) rcmp_d[7:0] = DIN[7:0];
         if (BYTE_SEL[1]) rcmp_d[8]   = DIN[8];
      end

      // Compare uses the pre-write RCMP; out-of-range values never match.
      vbl_set_c  = ce_q && (he_d == '0) && (32'(ve_d) == V_START + V_VIS);
      rast_set_c = ce_q && (32'(he_d) == H_START + H_VIS) && (ve_d == rcmp_q)
                   && (32'(rcmp_q) < V_TOTAL);
      vbl_d      = vbl_set_c  | (vbl_q  & ~INT_ACK[0]);
      rast_d     = rast_set_c | (rast_q & ~INT_ACK[1]);
   end

   always_ff @(posedge CLK_32M) begin
      if (RESET) begin
         div_q    <= '0;
         ce_q     <= 1'b0;
         he_q     <= '0;
         ve_q     <= '0;
         hblank_q <= 1'b1;
         vblank_q <= 1'b1;
         hsync_q  <= 1'b0;
         vsync_q  <= 1'b0;
         rcmp_q   <= 9'h1FF;
         vbl_q    <= 1'b0;
         rast_q   <= 1'b0;
`ifdef M72_SYNC_ADJUST_EN
         hadj_q   <= '0;
         vadj_q   <= '0;
`endif
      end else begin
         div_q    <= div_d;
         ce_q     <= ce_d;
         he_q     <= he_d;
         ve_q     <= ve_d;
         hblank_q <= hblank_d;
         vblank_q <= vblank_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
         rcmp_q   <= rcmp_d;
         vbl_q    <= vbl_d;
         rast_q   <= rast_d;
`ifdef M72_SYNC_ADJUST_EN
         hadj_q   <= hadj_d;
         vadj_q   <= vadj_d;
`endif
      end
   end

   assign CE_PIX   = ce_q;
   assign HE       = he_q;
   assign VE       = ve_q;
   assign HBLANK   = hblank_q;
   assign VBLANK   = vblank_q;
   assign HSYNC    = hsync_q;
   assign VSYNC    = vsync_q;
   assign VBL_IRQ  = vbl_q;
   assign RAST_IRQ = rast_q;

endmodule

// File: tb/tb_m72_video_timing.sv
// Directed bench for m72_video_timing using a reduced raster (40x36) so whole frames stay short.
module tb_m72_video_timing;

   localparam int unsigned HT = 40, HST = 4, HV = 28, HSS = 34, HSL = 3;
   localparam int unsigned VT = 36, VST = 4, VV = 24, VSS = 30, VSL = 2;
   localparam int FRAME_CLKS = 4 * 40 * 36;

   logic        CLK_32M = 1'b0;
   logic        RESET = 1'b1;
   logic        IOWR = 1'b0;
   logic [19:0] A = '0;
   logic [15:0] DIN = '0;
   logic [1:0]  BYTE_SEL = '0;
   logic [1:0]  INT_ACK = '0;
`ifdef M72_SYNC_ADJUST_EN
   logic [3:0]  H_ADJ = '0;
   logic [3:0]  V_ADJ = '0;
`endif
   logic        CE_PIX;
   logic [8:0]  HE, VE;
   logic        HBLANK, VBLANK, HSYNC, VSYNC, VBL_IRQ, RAST_IRQ;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      int he; int ve; int hbl; int vbl; int hs; int vs;
   } vec_t;
   vec_t vecs[20];

   m72_video_timing #(
      .H_TOTAL(HT), .H_START(HST), .H_VIS(HV), .HS_START(HSS), .HS_LEN(HSL),
      .V_TOTAL(VT), .V_START(VST), .V_VIS(VV), .VS_START(VSS), .VS_LEN(VSL)
   ) dut (
      .CLK_32M(CLK_32M), .RESET(RESET), .IOWR(IOWR), .A(A), .DIN(DIN),
      .BYTE_SEL(BYTE_SEL), .INT_ACK(INT_ACK),
`ifdef M72_SYNC_ADJUST_EN
      .H_ADJ(H_ADJ), .V_ADJ(V_ADJ),
`endif
      .CE_PIX(CE_PIX), .HE(HE), .VE(VE), .HBLANK(HBLANK), .VBLANK(VBLANK),
      .HSYNC(HSYNC), .VSYNC(VSYNC), .VBL_IRQ(VBL_IRQ), .RAST_IRQ(RAST_IRQ)
   );

   always #5 CLK_32M = ~CLK_32M;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK_32M);
      @(negedge CLK_32M);
   endtask

   task automatic wait_pos(input int h, input int v, input string name);
      int k;
      k = 0;
      while (!(HE == 9'(h) && VE == 9'(v)) && k < 20000) begin
         tick();
         k++;
      end
      if (k >= 20000) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s: timeout waiting for HE=%0d VE=%0d", name, h, v);
      end
   endtask

   task automatic cpu_wr(input logic [19:0] addr, input logic [15:0] d, input logic [1:0] bs);
      A = addr; DIN = d; BYTE_SEL = bs; IOWR = 1'b1;
      tick();
      IOWR = 1'b0; BYTE_SEL = 2'b00;
   endtask

   // Counts IRQ rising edges over n clocks and records where the first of each occurred.
   task automatic watch(input int n, output int rr, output int rh, output int rv,
                        output int vr, output int vh, output int vv);
      logic pr, pv;
      rr = 0; rh = -1; rv = -1; vr = 0; vh = -1; vv = -1;
      for (int k = 0; k < n; k++) begin
         pr = RAST_IRQ;
         pv = VBL_IRQ;
         tick();
         if (RAST_IRQ && !pr) begin
            rr++;
            if (rr == 1) begin rh = int'(HE); rv = int'(VE); end
         end
         if (VBL_IRQ && !pv) begin
            vr++;
            if (vr == 1) begin vh = int'(HE); vv = int'(VE); end
         end
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_ce"},    int'(CE_PIX),   0);
      check({tag, "_he"},    int'(HE),       0);
      check({tag, "_ve"},    int'(VE),       0);
      check({tag, "_hbl"},   int'(HBLANK),   1);
      check({tag, "_vbl"},   int'(VBLANK),   1);
      check({tag, "_hs"},    int'(HSYNC),    0);
      check({tag, "_vs"},    int'(VSYNC),    0);
      check({tag, "_virq"},  int'(VBL_IRQ),  0);
      check({tag, "_rirq"},  int'(RAST_IRQ), 0);
   endtask

   // After RESET drops: CE_PIX high in the 4th clock, HE steps when it ends.
   task automatic check_ce_start(input string tag);
      tick(); check({tag, "_ce1"}, int'(CE_PIX), 0);
      tick(); check({tag, "_ce2"}, int'(CE_PIX), 0);
      tick(); check({tag, "_ce3"}, int'(CE_PIX), 1);
      tick(); check({tag, "_ce4"}, int'(CE_PIX), 0);
      check({tag, "_he_step"}, int'(HE), 1);
   endtask

   initial begin
      int cnt, bad, wrap, pv;
      int rr, rh, rv, vr, vh, vv, k;

      // Horizontal edges on a visible line, then vertical edges at a visible column.
      vecs[0]  = '{3,  5, 1, 0, 0, 0};
      vecs[1]  = '{4,  5, 0, 0, 0, 0};
      vecs[2]  = '{31, 5, 0, 0, 0, 0};
      vecs[3]  = '{32, 5, 1, 0, 0, 0};
      vecs[4]  = '{33, 5, 1, 0, 0, 0};
      vecs[5]  = '{34, 5, 1, 0, 1, 0};
      vecs[6]  = '{36, 5, 1, 0, 1, 0};
      vecs[7]  = '{37, 5, 1, 0, 0, 0};
      vecs[8]  = '{39, 5, 1, 0, 0, 0};
      vecs[9]  = '{0,  6, 1, 0, 0, 0};
      vecs[10] = '{20, 27, 0, 0, 0, 0};
      vecs[11] = '{20, 28, 0, 1, 0, 0};
      vecs[12] = '{20, 29, 0, 1, 0, 0};
      vecs[13] = '{20, 30, 0, 1, 0, 1};
      vecs[14] = '{20, 31, 0, 1, 0, 1};
      vecs[15] = '{20, 32, 0, 1, 0, 0};
      vecs[16] = '{20, 35, 0, 1, 0, 0};
      vecs[17] = '{20, 0,  0, 1, 0, 0};
      vecs[18] = '{20, 3,  0, 1, 0, 0};
      vecs[19] = '{20, 4,  0, 0, 0, 0};

      @(negedge CLK_32M);
      RESET = 1'b1;
      repeat (3) tick();
      check_reset_state("reset");
      RESET = 1'b0;
      check_ce_start("start");

      for (int i = 0; i < 20; i++) begin
         wait_pos(vecs[i].he, vecs[i].ve, "vec_wait");
         check($sformatf("hblank@%0d,%0d", vecs[i].he, vecs[i].ve), int'(HBLANK), vecs[i].hbl);
         check($sformatf("vblank@%0d,%0d", vecs[i].he, vecs[i].ve), int'(VBLANK), vecs[i].vbl);
         check($sformatf("hsync@%0d,%0d",  vecs[i].he, vecs[i].ve), int'(HSYNC),  vecs[i].hs);
         check($sformatf("vsync@%0d,%0d",  vecs[i].he, vecs[i].ve), int'(VSYNC),  vecs[i].vs);
      end

      // One line: CE_PIX every 4th clock, 40 per line.
      wait_pos(0, 10, "line_wait");
      cnt = 0; bad = 0;
      for (int j = 0; j < 160; j++) begin
         if (int'(CE_PIX) != ((j % 4 == 3) ? 1 : 0)) bad++;
         if (CE_PIX) cnt++;
         tick();
      end
      check("ce_pattern_errors", bad, 0);
      check("ce_per_line", cnt, 40);
      check("line_end_he", int'(HE), 0);
      check("line_end_ve", int'(VE), 11);

      // One frame: 1440 CE_PIX and a VE wrap from 35.
      wait_pos(0, 0, "frame_wait");
      cnt = 0; wrap = -1;
      for (int j = 0; j < FRAME_CLKS; j++) begin
         if (CE_PIX) cnt++;
         pv = int'(VE);
         tick();
         if (VE == 9'd0 && pv != 0) wrap = pv;
      end
      check("ce_per_frame", cnt, 1440);
      check("ve_wrap_from", wrap, 35);
      check("frame_end_he", int'(HE), 0);

      // Clear the stale vblank request, program RCMP=20, watch a full frame.
      check("vbl_pending", int'(VBL_IRQ), 1);
      INT_ACK = 2'b01; tick(); INT_ACK = 2'b00;
      check("vbl_ack", int'(VBL_IRQ), 0);
      cpu_wr(20'h00040, 16'h0014, 2'b11);
      watch(FRAME_CLKS - 2, rr, rh, rv, vr, vh, vv);
      check("rast_rises", rr, 1);
      check("rast_he", rh, 32);
      check("rast_ve", rv, 20);
      check("vbl_rises", vr, 1);
      check("vbl_he", vh, 0);
      check("vbl_ve", vv, 28);

      INT_ACK = 2'b10; tick(); INT_ACK = 2'b00;
      check("rast_ack", int'(RAST_IRQ), 0);
      check("rast_ack_keeps_vbl", int'(VBL_IRQ), 1);
      INT_ACK = 2'b01; tick(); INT_ACK = 2'b00;
      check("vbl_ack2", int'(VBL_IRQ), 0);

      // Acknowledge held across the vblank tick: set wins.
      wait_pos(39, 27, "simul_wait");
      check("simul_pre_vbl", int'(VBL_IRQ), 0);
      k = 0;
      while (!CE_PIX && k < 4) begin tick(); k++; end
      INT_ACK = 2'b01; tick(); INT_ACK = 2'b00;
      check("simul_he", int'(HE), 0);
      check("simul_ve", int'(VE), 28);
      check("simul_vbl", int'(VBL_IRQ), 1);
      tick();
      check("simul_vbl_hold", int'(VBL_IRQ), 1);

      // Mid-line reset with both requests pending.
      wait_pos(30, 28, "midreset_wait");
      check("midreset_pre_rast", int'(RAST_IRQ), 1);
      RESET = 1'b1; tick();
      check_reset_state("midreset");
      RESET = 1'b0;
      check_ce_start("restart");

      // Reset RCMP (1FF) plus a write to a neighbouring address must never match.
      cpu_wr(20'h00042, 16'h0005, 2'b11);
      watch(FRAME_CLKS, rr, rh, rv, vr, vh, vv);
      check("rcmp_reset_no_rast", rr, 0);

      // RCMP=300 built from a high-only then a low-only write: no match over two frames.
      cpu_wr(20'h00040, 16'h0014, 2'b11);
      cpu_wr(20'h00040, 16'h0100, 2'b10);
      cpu_wr(20'h00040, 16'h002C, 2'b01);
      watch(2 * FRAME_CLKS, rr, rh, rv, vr, vh, vv);
      check("rcmp300_no_rast", rr, 0);

      // Clear bit 8 alone, then reload the low byte: back to line 20.
      cpu_wr(20'h00040, 16'h0000, 2'b10);
      cpu_wr(20'h00040, 16'h0014, 2'b01);
      watch(FRAME_CLKS, rr, rh, rv, vr, vh, vv);
      check("rcmp20_rises", rr, 1);
      check("rcmp20_he", rh, 32);
      check("rcmp20_ve", rv, 20);

`ifdef M72_SYNC_ADJUST_EN
      // H_ADJ=-2 changed mid-frame only takes effect from the next frame.
      wait_pos(0, 8, "adj_wait");
      H_ADJ = 4'hE;
      wait_pos(32, 10, "adj_w1"); check("adj_old_hs32", int'(HSYNC), 0);
      wait_pos(34, 10, "adj_w2"); check("adj_old_hs34", int'(HSYNC), 1);
      wait_pos(32, 5, "adj_w3");  check("adj_new_hs32", int'(HSYNC), 1);
      wait_pos(34, 5, "adj_w4");  check("adj_new_hs34", int'(HSYNC), 1);
      wait_pos(35, 5, "adj_w5");  check("adj_new_hs35", int'(HSYNC), 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
